writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_if.sv | 37 +++
 rtl/writeback.sv | 135 +++++++++++++
 tb/tb_writeback.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// Writeback stage bus: execute-stage commit request plus decode read ports and fetch PC.
// The instret counter port exists only when WRITEBACK_INSTRET_EN is defined.
interface writeback_if;
    logic        enable;
    logic [2:0]  wselector;
    logic [31:0] pc_in;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] gpr_rs;
    logic [31:0] gpr_rt;
    logic [31:0] fpr_rs;
    logic [31:0] fpr_rt;
    logic [31:0] pc;
    logic        done;
    logic        busy;
`ifdef WRITEBACK_INSTRET_EN
    logic [63:0] instret;
`endif

    modport master (
        output enable, wselector, pc_in, data, rd, rs_addr, rt_addr,
        input  gpr_rs, gpr_rt, fpr_rs, fpr_rt, pc, done, busy
`ifdef WRITEBACK_INSTRET_EN
        , input instret
`endif
    );

    modport slave (
        input  enable, wselector, pc_in, data, rd, rs_addr, rt_addr,
        output gpr_rs, gpr_rt, fpr_rs, fpr_rt, pc, done, busy
`ifdef WRITEBACK_INSTRET_EN
        , output instret
`endif
    );
endinterface

// File: rtl/writeback.sv
// Writeback stage: latches an execute result, commits it to the GPR/FPR files and PC one cycle later.
// Optional retired-instruction counter enabled by defining WRITEBACK_INSTRET_EN.
module writeback (
    input  logic       clk,
    input  logic       rstn,
    writeback_if.slave bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [2:0]  wsel_q, wsel_d;
    logic [31:0] pc_in_q, pc_in_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d;
    logic        done_q, done_d;

    logic [31:0] gpr_q [32];
    logic [31:0] fpr_q [32];

    logic capture;
    logic commit;
    logic gpr_we;
    logic fpr_we;

    // Enable is only honoured in IDLE, so a pulse arriving during COMMIT is dropped.
    always_comb begin
        capture = (state_q == ST_IDLE) && bus.enable;
        commit  = (state_q == ST_COMMIT);
        gpr_we  = commit && (wsel_q[1:0] == 2'b10) && (rd_q != 5'd0);
        fpr_we  = commit && (wsel_q[1:0] == 2'b11);
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d = state_q;
        wsel_d  = wsel_q;
        pc_in_d = pc_in_q;
        data_d  = data_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_COMMIT;
                    wsel_d  = bus.wselector;
                    pc_in_d = bus.pc_in;
                    data_d  = bus.data;
                    rd_d    = bus.rd;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                pc_d    = wsel_q[2] ? pc_in_q : (pc_q + 32'd4);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wsel_q  <= 3'b000;
            pc_in_q <= 32'h0;
            data_q  <= 32'h0;
            rd_q    <= 5'd0;
            pc_q    <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wsel_q  <= wsel_d;
            pc_in_q <= pc_in_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the register files are reset because zeroed contents after reset are architecturally visible.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= 32'h0;
                fpr_q[i] <= 32'h0;
            end
        end else begin
            if (gpr_we) begin
                gpr_q[rd_q] <= data_q;
            end
            if (fpr_we) begin
                fpr_q[rd_q] <= data_q;
            end
        end
    end

    // GPR 0 is hardwired to zero on read; FPR 0 is an ordinary register.
    assign bus.gpr_rs = (bus.rs_addr == 5'd0) ? 32'h0 : gpr_q[bus.rs_addr];
    assign bus.gpr_rt = (bus.rt_addr == 5'd0) ? 32'h0 : gpr_q[bus.rt_addr];
    assign bus.fpr_rs = fpr_q[bus.rs_addr];
    assign bus.fpr_rt = fpr_q[bus.rt_addr];

    assign bus.pc   = pc_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q == ST_COMMIT);

`ifdef WRITEBACK_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = commit ? (instret_q + 64'd1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            instret_q <= 64'h0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign bus.instret = instret_q;
`else
    // Counter disabled: no instret port or logic exists in this build.
`endif

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: stimulus pushes expected commits, a monitor checks them on each done pulse.
module tb_writeback;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    writeback_if bus_if ();

    writeback dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] gs;
        logic [31:0] gt;
        logic [31:0] fs;
        logic [31:0] ft;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_commit(input string name, input logic [31:0] pc, input logic [31:0] gs,
                                 input logic [31:0] gt, input logic [31:0] fs, input logic [31:0] ft);
        exp_t e;
        e.name = name;
        e.pc   = pc;
        e.gs   = gs;
        e.gt   = gt;
        e.fs   = fs;
        e.ft   = ft;
        e.due  = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] ws, input logic [4:0] rd, input logic [31:0] d,
                         input logic [31:0] pin, input logic [4:0] rs, input logic [4:0] rt);
        bus_if.wselector = ws;
        bus_if.rd        = rd;
        bus_if.data      = d;
        bus_if.pc_in     = pin;
        bus_if.rs_addr   = rs;
        bus_if.rt_addr   = rt;
        bus_if.enable    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.enable    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest expected commit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", bus_if.done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_pc"},      bus_if.pc,     e.pc);
                    check({e.name, "_gpr_rs"},  bus_if.gpr_rs, e.gs);
                    check({e.name, "_gpr_rt"},  bus_if.gpr_rt, e.gt);
                    check({e.name, "_fpr_rs"},  bus_if.fpr_rs, e.fs);
                    check({e.name, "_fpr_rt"},  bus_if.fpr_rt, e.ft);
                    check({e.name, "_latency"}, cyc,           e.due);
                    check({e.name, "_busy"},    bus_if.busy,   1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        rstn             = 1'b0;
        bus_if.enable    = 1'b0;
        bus_if.wselector = 3'b000;
        bus_if.pc_in     = 32'h0;
        bus_if.data      = 32'h0;
        bus_if.rd        = 5'd0;
        bus_if.rs_addr   = 5'd5;
        bus_if.rt_addr   = 5'd0;
        idle(2);

        check("rst_pc",     bus_if.pc,     32'h0);
        check("rst_done",   bus_if.done,   1'b0);
        check("rst_busy",   bus_if.busy,   1'b0);
        check("rst_gpr_rs", bus_if.gpr_rs, 32'h0);
        check("rst_fpr_rt", bus_if.fpr_rt, 32'h0);
`ifdef WRITEBACK_INSTRET_EN
        check("rst_instret", bus_if.instret, 64'h0);
`endif
        rstn = 1'b1;
        idle(1);

        // Plain GPR write, then a write to GPR 0 that must be discarded.
        expect_commit("gpr5", 32'h4, 32'h1234, 32'h1234, 32'h0, 32'h0);
        drive(3'b010, 5'd5, 32'h1234, 32'h0, 5'd5, 5'd5);
        check("gpr5_busy", bus_if.busy, 1'b1);
        idle(3);

        expect_commit("gpr0", 32'h8, 32'h0, 32'h1234, 32'h0, 32'h0);
        drive(3'b010, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd5);
        idle(3);

        // Jump and link: GPR write and PC load together.
        expect_commit("jal", 32'h100, 32'h8, 32'h1234, 32'h0, 32'h0);
        drive(3'b110, 5'd31, 32'h8, 32'h100, 5'd31, 5'd5);
        idle(3);

        // FPR 0 is writable while GPR 0 still reads zero.
        expect_commit("fpr0", 32'h104, 32'h0, 32'h1234, 32'h3F800000, 32'h0);
        drive(3'b011, 5'd0, 32'h3F800000, 32'h0, 5'd0, 5'd5);
        idle(3);

        // Bit1 clear: PC advances, no register write.
        expect_commit("nowrite", 32'h108, 32'h1234, 32'h1234, 32'h0, 32'h0);
        drive(3'b001, 5'd5, 32'hDEAD, 32'h0, 5'd5, 5'd5);
        idle(3);

        // Back-to-back enables: the second lands in COMMIT and must be ignored.
        expect_commit("b2b", 32'h10C, 32'h77, 32'h1234, 32'h0, 32'h0);
        drive(3'b010, 5'd7, 32'h77, 32'h0, 5'd7, 5'd5);
        check("b2b_busy", bus_if.busy, 1'b1);
        drive(3'b110, 5'd7, 32'h99, 32'h500, 5'd7, 5'd5);
        idle(4);

        expect_commit("fpr5", 32'h110, 32'h1234, 32'h0, 32'hCAFE, 32'h3F800000);
        drive(3'b011, 5'd5, 32'hCAFE, 32'h0, 5'd5, 5'd0);
        idle(3);

        // PC wrap at the top of the address space.
        expect_commit("wrap_load", 32'hFFFFFFFC, 32'h0, 32'h1234, 32'h0, 32'hCAFE);
        drive(3'b100, 5'd9, 32'h1, 32'hFFFFFFFC, 5'd9, 5'd5);
        idle(3);
        expect_commit("wrap_inc", 32'h0, 32'h0, 32'h1234, 32'h0, 32'hCAFE);
        drive(3'b000, 5'd9, 32'h2, 32'h0, 5'd9, 5'd5);
        idle(3);
`ifdef WRITEBACK_INSTRET_EN
        check("instret_count", bus_if.instret, 64'd9);
`endif

        // Reset during COMMIT: no write, no PC update, no done; enable held high under reset.
        drive(3'b010, 5'd3, 32'h33, 32'h0, 5'd3, 5'd5);
        check("abort_busy", bus_if.busy, 1'b1);
        rstn             = 1'b0;
        bus_if.wselector = 3'b110;
        bus_if.rd        = 5'd4;
        bus_if.pc_in     = 32'h200;
        bus_if.enable    = 1'b1;
        idle(2);
        check("abort_pc_in_rst", bus_if.pc, 32'h0);
        bus_if.enable = 1'b0;
        rstn          = 1'b1;
        idle(4);
        check("abort_gpr3",   bus_if.gpr_rs, 32'h0);
        check("abort_gpr5",   bus_if.gpr_rt, 32'h0);
        check("abort_fpr5",   bus_if.fpr_rt, 32'h0);
        check("abort_pc",     bus_if.pc,     32'h0);
        check("abort_busy_0", bus_if.busy,   1'b0);
`ifdef WRITEBACK_INSTRET_EN
        check("abort_instret", bus_if.instret, 64'h0);
`endif

        // Normal operation resumes after the aborted commit.
        expect_commit("post_rst", 32'h4, 32'h33, 32'h0, 32'h0, 32'h0);
        drive(3'b010, 5'd3, 32'h33, 32'h0, 5'd3, 5'd5);
        idle(4);
`ifdef WRITEBACK_INSTRET_EN
        check("post_instret", bus_if.instret, 64'd1);
`endif

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
